// File: rtl/hist_frame_ctrl.sv
// Frame sequencer for one external histogram accumulator: clears it, gates samples in,
// tracks count and wrap-around, and hands the frame result downstream over valid/ready.
module hist_frame_ctrl #(
  parameter int DATA_WIDTH = 14,
  parameter int CNT_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  acc_clear,
  output logic                  acc_valid,
  output logic [DATA_WIDTH-1:0] acc_data,
  input  logic [DATA_WIDTH-1:0] acc_q,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [CNT_WIDTH-1:0]  res_count,
  output logic                  res_ovf,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  frame_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCUM  = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  // Carry out of the unsigned sum, i.e. the accumulator is about to wrap.
  function automatic logic add_carry(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_WIDTH];
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic                  w_err;
  logic                  w_accept;
  logic                  r_pend;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [CNT_WIDTH-1:0]  r_res_count;
  logic                  r_res_ovf;
  logic                  r_err;

  assign w_accept = (r_state == S_ACCUM) && in_valid;

  // Next-state decode and protocol-violation detection.
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_next = S_CLEAR;
        end else if (frame_end) begin
          w_err = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_next = S_ACCUM;
        w_err  = frame_start | frame_end;
      end
      S_ACCUM: begin
        if (frame_end) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_ACCUM;
        end
        w_err = frame_start;
      end
      S_DRAIN: begin
        w_next = S_REPORT;
        w_err  = frame_start | frame_end;
      end
      S_REPORT: begin
        w_err = frame_end;
        if (res_ready) begin
          w_next = (r_pend | frame_start) ? S_CLEAR : S_IDLE;
        end else begin
          w_next = S_REPORT;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, pending start request and error pulse registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      if (w_next == S_CLEAR) begin
        r_pend <= 1'b0;
      end else if ((r_state == S_REPORT) && frame_start) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Per-frame sample counter (saturating) and sticky wrap flag.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
      r_ovf <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (!(&r_cnt)) begin
        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      r_ovf <= r_ovf | add_carry(acc_q, in_data);
    end
  end

  // Result capture once the accumulator has absorbed the last sample.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_res_data  <= {DATA_WIDTH{1'b0}};
      r_res_count <= {CNT_WIDTH{1'b0}};
      r_res_ovf   <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_res_data  <= acc_q;
      r_res_count <= r_cnt;
      r_res_ovf   <= r_ovf;
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign acc_clear = (r_state == S_CLEAR);
  assign acc_valid = w_accept;
  assign acc_data  = in_data;
  assign res_valid = (r_state == S_REPORT);
  assign busy      = (r_state != S_IDLE);
  assign res_data  = r_res_data;
  assign res_count = r_res_count;
  assign res_ovf   = r_res_ovf;
  assign frame_err = r_err;

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Directed bench for hist_frame_ctrl with a behavioural accumulator and a result scoreboard.
module tb_hist_frame_ctrl;

  localparam int DW = 14;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          arstn;
  logic          frame_start, frame_end, in_valid, res_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, acc_clear, acc_valid, res_ovf, res_valid, busy, frame_err;
  logic [DW-1:0] acc_data, acc_q, res_data;
  logic [CW-1:0] res_count;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          o;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] smp[$];
  int            n_pass = 0;
  int            n_total = 0;

  hist_frame_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .arstn(arstn), .frame_start(frame_start), .frame_end(frame_end),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .acc_clear(acc_clear), .acc_valid(acc_valid), .acc_data(acc_data), .acc_q(acc_q),
    .res_data(res_data), .res_count(res_count), .res_ovf(res_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // External accumulator: wraps modulo 2^DW.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) acc_q <= '0;
    else if (acc_clear) acc_q <= '0;
    else if (acc_valid) acc_q <= acc_q + acc_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Runs one frame from smp[] and pushes the reference-model result.
  task automatic drive_frame(input bit do_start, input bit coincide, input bit gaps,
                             input bit inject_err);
    int   s;
    bit   ov;
    int   n;
    exp_t e;
    s  = 0;
    ov = 1'b0;
    n  = smp.size();
    foreach (smp[i]) begin
      s += int'(smp[i]);
      if (s >= (1 << DW)) begin
        s -= (1 << DW);
        ov = 1'b1;
      end
    end
    e.d = s[DW-1:0];
    e.c = n[CW-1:0];
    e.o = ov;
    sb.push_back(e);
    if (do_start) begin
      frame_start = 1'b1;
      frame_end   = coincide;
      tick();
      frame_start = 1'b0;
      frame_end   = 1'b0;
    end
    chk("clear_pulse", acc_clear, 1);
    chk("clear_no_err", frame_err, 0);
    chk("clear_not_ready", in_ready, 0);
    tick();
    chk("accum_ready", in_ready, 1);
    chk("accum_clear_low", acc_clear, 0);
    if (n == 0) begin
      frame_end = 1'b1;
      tick();
    end else begin
      for (int i = 0; i < n; i++) begin
        if (gaps && (i % 2 == 1)) begin
          in_valid = 1'b0;
          tick();
        end
        if (inject_err && i == 1) begin
          in_valid    = 1'b0;
          frame_start = 1'b1;
          tick();
          frame_start = 1'b0;
          chk("err_pulse", frame_err, 1);
          chk("err_state_kept", in_ready, 1);
        end
        in_data   = smp[i];
        in_valid  = 1'b1;
        frame_end = (i == n - 1);
        #1;
        chk("acc_valid", acc_valid, 1);
        tick();
        if (inject_err && i == 1) chk("err_one_cycle", frame_err, 0);
      end
    end
    in_valid  = 1'b0;
    frame_end = 1'b0;
    chk("drain_no_valid", res_valid, 0);
    chk("drain_busy", busy, 1);
    tick();
    chk("report_valid", res_valid, 1);
  endtask

  // Waits for a result, applies backpressure, then handshakes and scores it.
  task automatic collect(input int hold, input bit pend);
    exp_t e;
    int   guard;
    guard = 0;
    while (res_valid !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("res_valid_timeout", res_valid, 1);
    chk("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{d: '0, c: '0, o: 1'b0};
    for (int k = 0; k < hold; k++) begin
      res_ready   = 1'b0;
      frame_start = (pend && k == 1);
      tick();
      frame_start = 1'b0;
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, e.d);
      chk("hold_count", res_count, e.c);
      chk("hold_err", frame_err, 0);
    end
    chk("res_data", res_data, e.d);
    chk("res_count", res_count, e.c);
    chk("res_ovf", res_ovf, e.o);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_drop", res_valid, 0);
    chk("hs_next_clear", acc_clear, pend);
    chk("hs_busy", busy, pend);
  endtask

  initial begin
    arstn = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    in_valid = 1'b0; res_ready = 1'b0; in_data = 14'd5;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_acc_data", acc_data, 5);
    tick();
    arstn = 1'b1;
    tick();

    // frame_end while idle
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("idle_end_err", frame_err, 1);
    chk("idle_end_busy", busy, 0);
    tick();
    chk("idle_end_err_clear", frame_err, 0);

    smp = '{14'd10, 14'd20, 14'd30};
    drive_frame(1'b1, 1'b0, 1'b0, 1'b0);
    collect(0, 1'b0);

    smp = '{14'd16000, 14'd1000};
    drive_frame(1'b1, 1'b0, 1'b0, 1'b1);
    collect(0, 1'b0);

    smp = {};
    drive_frame(1'b1, 1'b0, 1'b0, 1'b0);
    collect(0, 1'b0);

    smp = '{14'd5, 14'd7, 14'd9, 14'd11};
    drive_frame(1'b1, 1'b1, 1'b1, 1'b0);
    collect(5, 1'b1);
    smp = '{14'd1, 14'd2, 14'd3};
    drive_frame(1'b0, 1'b0, 1'b0, 1'b0);
    collect(0, 1'b0);

    // Reset in the middle of accumulation
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    in_data = 14'd100; in_valid = 1'b1;
    tick();
    in_data = 14'd200;
    tick();
    #2;
    arstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc_valid", acc_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_res_count", res_count, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    in_valid = 1'b0;
    tick();
    arstn = 1'b1;
    tick();

    smp = '{14'd40, 14'd50};
    drive_frame(1'b1, 1'b0, 1'b0, 1'b0);
    collect(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
